// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: SPI mode-0 slave that returns 12-bit channel values from a
// small register file. Each 16-bit frame carries the channel command for the
// next frame, so data comes back one frame late (classic two-transaction A2D
// read). All SPI inputs are synchronized into the clk domain and sampled.
module a2d_spi_resp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        wr_en,
  input  logic [2:0]  wr_chnl,
  input  logic [11:0] wr_data,
  output logic        frame_done,
  output logic        cmd_err,
  output logic [2:0]  cur_chnl
);

  typedef enum logic [1:0] {IDLE, ACTIVE, OVERRUN} state_t;

  state_t            state_q, state_d;
  logic [2:0]        ss_q, sclk_q;
  logic [1:0]        mosi_q;
  logic [7:0][11:0]  val_q;
  logic [4:0]        cnt_q, cnt_d;
  logic [15:0]       rx_q, rx_d;
  logic [15:0]       tx_q, tx_d;
  logic [2:0]        cur_q, cur_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic ss_fall, ss_rise, sclk_rise, sclk_fall;

  // Two-flop synchronizers plus one history flop for SS_n/SCLK edge detect.
  // SS_n flops reset low so a reset released mid-frame (SS_n still low)
  // never looks like a fresh fall; the rise seen when SS_n is high is
  // harmless in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q   <= 3'b000;
      sclk_q <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      ss_q   <= {ss_q[1:0], SS_n};
      sclk_q <= {sclk_q[1:0], SCLK};
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  assign ss_fall   =  ss_q[2]   & ~ss_q[1];
  assign ss_rise   = ~ss_q[2]   &  ss_q[1];
  assign sclk_rise = ~sclk_q[2] &  sclk_q[1];
  assign sclk_fall =  sclk_q[2] & ~sclk_q[1];

  // Channel register file; reset pattern puts each channel's index in its LSBs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 8; n++) val_q[n] <= {9'h000, 3'(n)};
    end else if (wr_en) begin
      val_q[wr_chnl] <= wr_data;
    end
  end

  // FSM and datapath state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      cur_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      cur_q   <= cur_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state: load on SS_n fall (SCLK edges that cycle are dropped), shift
  // while ACTIVE, close out the frame on SS_n rise.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    cur_d   = cur_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          // Snapshot taken here, so later writes cannot disturb this frame.
          tx_d    = {4'h0, val_q[cur_q]};
          rx_d    = '0;
          cnt_d   = '0;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = IDLE;
          if (cnt_q == 5'd16) begin
            done_d = 1'b1;
            cur_d  = rx_q[13:11];
            err_d  = (rx_q[15:14] != 2'b00) || (rx_q[10:0] != 11'd0);
          end
        end else begin
          if (sclk_rise) begin
            if (cnt_q == 5'd16) begin
              state_d = OVERRUN;
            end else begin
              rx_d  = {rx_q[14:0], mosi_q[1]};
              cnt_d = cnt_q + 5'd1;
            end
          end
          if (sclk_fall) tx_d = {tx_q[14:0], 1'b0};
        end
      end
      OVERRUN: begin
        if (ss_rise) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign MISO       = (state_q == ACTIVE) & tx_q[15];
  assign frame_done = done_q;
  assign cmd_err    = err_q;
  assign cur_chnl   = cur_q;

endmodule
